feature_frame_assembler: RTL and testbench

- Upstream neighbour of hdc_sensor_fusion.
- Accepts quantized sensor features as a serial stream, one channel per beat, and packs TOTAL_NUM_CHANNEL beats into one wide feature frame.
- Presents each completed frame on the fin_valid/fin_ready interface that hdc_sensor_fusion consumes.
- A two-bank (ping-pong) frame buffer lets the next frame be assembled while the previous frame waits for the encoder.

---
 rtl/hdc_fuse_pkg.sv | 17 +
 rtl/frame_pingpong_buf.sv | 53 +++++
 rtl/feature_frame_assembler.sv | 83 ++++++++
 tb/tb_feature_frame_assembler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_fuse_pkg.sv
// Shared types and defaults for the HDC sensor-fusion front end.
// Frame geometry defaults and the channel-counter width helper.
package hdc_fuse_pkg;

  localparam int TOTAL_NUM_CHANNEL_DFLT = 214;
  localparam int CHANNEL_WIDTH_DFLT     = 4;

  function automatic int ceil_log2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CH_CNT_WIDTH = ceil_log2(TOTAL_NUM_CHANNEL_DFLT);

  typedef logic [CHANNEL_WIDTH_DFLT-1:0] feature_t;
  typedef feature_t [TOTAL_NUM_CHANNEL_DFLT-1:0] frame_t;

endpackage

// File: rtl/frame_pingpong_buf.sv
// Two-bank frame buffer: one bank fills while the other waits
// for the encoder. Holds bank data, full flags and both pointers.
module frame_pingpong_buf #(
  parameter int NCH = 4,
  parameter int W   = 4,
  parameter int CW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_idx,
  input  logic [W-1:0]      wr_data,
  input  logic              wr_done,
  output logic              wr_ok,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [NCH*W-1:0]  rd_data
);

  logic [1:0][NCH*W-1:0] bank;
  logic [1:0]            full;
  logic [1:0]            full_n;
  logic                  wr_sel;
  logic                  rd_sel;
  logic                  rd_fire;

  assign wr_ok    = ~full[wr_sel];
  assign rd_valid = full[rd_sel];
  assign rd_data  = bank[rd_sel];
  assign rd_fire  = full[rd_sel] & rd_ready;

  // Fill and drain always target different banks, so both apply.
  always_comb begin
    full_n = full;
    if (wr_done) full_n[wr_sel] = 1'b1;
    if (rd_fire) full_n[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank   <= '0;
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      full <= full_n;
      if (wr_done) wr_sel <= ~wr_sel;
      if (rd_fire) rd_sel <= ~rd_sel;
      if (wr_en) bank[wr_sel][wr_idx*W +: W] <= wr_data;
    end
  end

endmodule

// File: rtl/feature_frame_assembler.sv
// Packs serial channel features into frames for hdc_sensor_fusion.
// Define LAST_CHECK_EN to enforce in_last framing and count drops.
module feature_frame_assembler
  import hdc_fuse_pkg::*;
#(
  parameter int TOTAL_NUM_CHANNEL = TOTAL_NUM_CHANNEL_DFLT,
  parameter int CHANNEL_WIDTH     = CHANNEL_WIDTH_DFLT,
  parameter int ERR_CNT_WIDTH     = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CHANNEL_WIDTH-1:0]               in_data,
  input  logic                                   in_valid,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic [TOTAL_NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
  output logic                                   fin_valid,
  input  logic                                   fin_ready,
  output logic                                   frame_err,
  output logic [ERR_CNT_WIDTH-1:0]               err_cnt
);

  localparam int CW = ceil_log2(TOTAL_NUM_CHANNEL);

  logic [CW-1:0] ch_cnt;
  logic          wr_ok;
  logic          accept;
  logic          last_ch;
  logic          done;
  logic          drop;

  assign in_ready = wr_ok;
  assign accept   = in_valid & wr_ok;
  assign last_ch  = (ch_cnt == CW'(TOTAL_NUM_CHANNEL - 1));

`ifdef LAST_CHECK_EN
  assign drop = accept & (in_last ^ last_ch);
  assign done = accept & last_ch & in_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= drop;
      if (drop && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = in_last;
  assign drop        = 1'b0;
  assign done        = accept & last_ch;
  assign frame_err   = 1'b0;
  assign err_cnt     = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt <= '0;
    end else if (accept) begin
      ch_cnt <= (last_ch | drop) ? '0 : ch_cnt + 1'b1;
    end
  end

  frame_pingpong_buf #(
    .NCH (TOTAL_NUM_CHANNEL),
    .W   (CHANNEL_WIDTH),
    .CW  (CW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept),
    .wr_idx   (ch_cnt),
    .wr_data  (in_data),
    .wr_done  (done),
    .wr_ok    (wr_ok),
    .rd_ready (fin_ready),
    .rd_valid (fin_valid),
    .rd_data  (features_top)
  );

endmodule

// File: tb/tb_feature_frame_assembler.sv
// Bench for feature_frame_assembler: directed vectors on a 4-channel
// build plus a scoreboarded random run on the default geometry.
module tb_feature_frame_assembler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] feat;
  logic        fv;
  logic        fr4 = 1'b0;
  logic        ferr;
  logic [7:0]  ecnt;

  logic [3:0]   d_data = '0;
  logic         d_valid = 1'b0;
  logic         d_last = 1'b0;
  logic         d_ready;
  logic [855:0] d_feat;
  logic         d_fv;
  logic         d_fr = 1'b0;
  logic         d_ferr;
  logic [7:0]   d_ecnt;

  feature_frame_assembler #(
    .TOTAL_NUM_CHANNEL (4),
    .CHANNEL_WIDTH     (4),
    .ERR_CNT_WIDTH     (8)
  ) u4 (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .features_top (feat),
    .fin_valid    (fv),
    .fin_ready    (fr4),
    .frame_err    (ferr),
    .err_cnt      (ecnt)
  );

  feature_frame_assembler ud (
    .clk          (clk),
    .rst          (rst),
    .in_data      (d_data),
    .in_valid     (d_valid),
    .in_last      (d_last),
    .in_ready     (d_ready),
    .features_top (d_feat),
    .fin_valid    (d_fv),
    .fin_ready    (d_fr),
    .frame_err    (d_ferr),
    .err_cnt      (d_ecnt)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [855:0] act,
                     input logic [855:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  d;
    logic        v;
    logic        l;
    logic        fr;
    logic        e_rdy;
    logic        e_fv;
    logic        chk_f;
    logic [15:0] e_f;
  } vec_t;

  function automatic vec_t mk(logic [3:0] d, logic v, logic l, logic fr,
                              logic er, logic ef, logic cf,
                              logic [15:0] f);
    vec_t r;
    r.d = d; r.v = v; r.l = l; r.fr = fr;
    r.e_rdy = er; r.e_fv = ef; r.chk_f = cf; r.e_f = f;
    return r;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    d_valid = 1'b0;
    fr4 = 1'b0;
    d_fr = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    bit acc;
    acc = 1'b0;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      acc = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=stall want=accept data=%0h", d);
    end
  endtask

  int          mon_cnt = 0;
  bit          mon_en = 1'b0;
  logic [15:0] mon_feat = '0;
  always @(negedge clk) begin
    if (mon_en && fv && fr4) begin
      mon_cnt++;
      mon_feat = feat;
    end
  end

  vec_t tbl [6];
  logic [855:0] q [$];
  logic [855:0] exp_f;
  logic [3:0]   rv;
  int           got;

  initial begin
    tbl[0] = mk(4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    tbl[1] = mk(4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    tbl[2] = mk(4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    tbl[3] = mk(4'h4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h4321);
    tbl[4] = mk(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    tbl[5] = mk(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);

    // reset state
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fin_valid", fv, 0);
    chk("rst_features", feat, 0);
    chk("rst_frame_err", ferr, 0);
    chk("rst_err_cnt", ecnt, 0);

    // single frame, table driven
    for (int i = 0; i < 6; i++) begin
      in_data = tbl[i].d;
      in_valid = tbl[i].v;
      in_last = tbl[i].l;
      fr4 = tbl[i].fr;
      cyc();
      chk($sformatf("t1_rdy%0d", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("t1_fv%0d", i), fv, tbl[i].e_fv);
      if (tbl[i].chk_f) chk($sformatf("t1_feat%0d", i), feat, tbl[i].e_f);
    end
    in_valid = 1'b0;
    fr4 = 1'b0;

    // back-pressure with both banks full
    do_reset();
    for (int b = 1; b <= 8; b++) send(4'(b), (b % 4) == 0);
    chk("t2_full_rdy", in_ready, 0);
    chk("t2_full_fv", fv, 1);
    chk("t2_full_feat", feat, 16'h4321);
    in_data = 4'h9;
    in_last = 1'b0;
    in_valid = 1'b1;
    repeat (2) cyc();
    chk("t2_hold_rdy", in_ready, 0);
    chk("t2_hold_feat", feat, 16'h4321);
    fr4 = 1'b1;
    cyc();
    fr4 = 1'b0;
    in_valid = 1'b0;
    chk("t2_pop_rdy", in_ready, 1);
    chk("t2_pop_fv", fv, 1);
    chk("t2_pop_feat", feat, 16'h8765);
    for (int b = 9; b <= 12; b++) send(4'(b), b == 12);
    chk("t2_refill_rdy", in_ready, 0);
    chk("t2_refill_feat", feat, 16'h8765);
    fr4 = 1'b1;
    cyc();
    chk("t2_f3_fv", fv, 1);
    chk("t2_f3_feat", feat, 16'hCBA9);
    cyc();
    chk("t2_empty_fv", fv, 0);
    fr4 = 1'b0;

    // early in_last
    do_reset();
    send(4'h1, 1'b0);
    send(4'h2, 1'b1);
`ifdef LAST_CHECK_EN
    chk("t3_err_pulse", ferr, 1);
    chk("t3_err_cnt", ecnt, 1);
    chk("t3_no_fv", fv, 0);
    cyc();
    chk("t3_err_clear", ferr, 0);
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    send(4'h7, 1'b0);
    send(4'h8, 1'b1);
    chk("t3_clean_fv", fv, 1);
    chk("t3_clean_feat", feat, 16'h8765);
`else
    chk("t3_err_pulse", ferr, 0);
    chk("t3_err_cnt", ecnt, 0);
    chk("t3_no_fv", fv, 0);
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    chk("t3_count_fv", fv, 1);
    chk("t3_count_feat", feat, 16'h6521);
`endif

    // many one-beat frames
    do_reset();
    fr4 = 1'b1;
    for (int i = 0; i < 300; i++) send(4'(i), 1'b1);
`ifdef LAST_CHECK_EN
    chk("t4_err_sat", ecnt, 8'hFF);
    chk("t4_no_fv", fv, 0);
`else
    chk("t4_err_zero", ecnt, 0);
`endif
    fr4 = 1'b0;

    // reset mid-frame with one bank pending
    do_reset();
    for (int b = 1; b <= 4; b++) send(4'(b), b == 4);
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    chk("t5_pend_fv", fv, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_fv", fv, 0);
    chk("t5_rst_rdy", in_ready, 1);
    cyc();
    rst = 1'b0;
    mon_cnt = 0;
    mon_en = 1'b1;
    fr4 = 1'b1;
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    send(4'hC, 1'b0);
    send(4'hD, 1'b1);
    repeat (6) cyc();
    mon_en = 1'b0;
    fr4 = 1'b0;
    chk("t5_one_frame", mon_cnt, 1);
    chk("t5_frame_data", mon_feat, 16'hDCBA);

    // random frames on default geometry
    do_reset();
    got = 0;
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          exp_f = '0;
          for (int i = 0; i < 214; i++) begin
            bit acc;
            if ($urandom_range(0, 3) == 0) begin
              d_valid = 1'b0;
              repeat ($urandom_range(0, 15)) cyc();
            end
            rv = 4'($urandom);
            exp_f[i*4 +: 4] = rv;
            d_data = rv;
            d_last = (i == 213);
            d_valid = 1'b1;
            acc = 1'b0;
            for (int k = 0; k < 5000 && !acc; k++) begin
              acc = d_ready;
              cyc();
            end
            if (!acc) begin
              total++;
              bad++;
              $display("FAIL rand_beat_timeout got=stall want=accept f=%0d", f);
            end
          end
          d_valid = 1'b0;
          q.push_back(exp_f);
        end
      end
      begin
        int c;
        bit hs;
        c = 0;
        while (got < 20 && c < 60000) begin
          d_fr = 1'b0;
          repeat ($urandom_range(0, 15)) begin
            cyc();
            c++;
          end
          d_fr = 1'b1;
          hs = 1'b0;
          while (!hs && c < 60000) begin
            @(negedge clk);
            if (d_fv) begin
              hs = 1'b1;
              if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rand_unexpected got=frame want=none");
              end else begin
                chk($sformatf("rand_frame%0d", got), d_feat, q.pop_front());
              end
              got++;
            end
            cyc();
            c++;
          end
        end
        d_fr = 1'b0;
      end
    join
    chk("rand_count", got, 20);
    chk("rand_left", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
